// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction encoding, game states and
// playfield entity codes, used by the input controller and the game controller.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    localparam logic [1:0] GAME_STATE_IDLE  = 2'd0;
    localparam logic [1:0] GAME_STATE_ALIVE = 2'd1;
    localparam logic [1:0] GAME_STATE_DEAD  = 2'd2;
    localparam logic [1:0] GAME_STATE_WIN   = 2'd3;

    localparam logic [1:0] ENTITY_EMPTY = 2'd0;
    localparam logic [1:0] ENTITY_SNAKE = 2'd1;
    localparam logic [1:0] ENTITY_FOOD  = 2'd2;
    localparam logic [1:0] ENTITY_WALL  = 2'd3;

    // Flipping the axis-sign bit gives the reverse heading.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Single-bit debouncer: the accepted level follows the raw input only after
// the raw input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 252000
) (
    input  logic clk_25_2,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    // Count disagreeing cycles; any agreeing sample restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (btn_raw != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = btn_raw;
                rise_d  = btn_raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; rise is a one-cycle strobe aligned with the new level.
    always_ff @(posedge clk_25_2) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/snake_input_controller.sv
// Snake input controller: debounces the four direction buttons, queues legal
// turns in a small circular buffer and applies one turn per game tick.
module snake_input_controller
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 252000,
    parameter int QUEUE_DEPTH     = 2
) (
    input  logic       clk_25_2,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       tick,
    input  logic [1:0] game_state,
    output logic [1:0] mov_dir,
    output logic [2:0] queue_count,
    output logic       press_dropped
);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    logic [3:0] lvl_w, rise_w, press_w;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk_25_2 (clk_25_2),
            .rst      (rst),
            .btn_raw  (btn[i]),
            .level    (lvl_w[i]),
            .rise     (rise_w[i])
        );
    end

    assign press_w = rise_w & lvl_w;

    logic [1:0]    mem_q [QUEUE_DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, tail_idx;
    logic [2:0]    cnt_q, cnt_d, cnt_after;
    logic [1:0]    mov_q, mov_d, ref_dir, ev_dir;
    logic          drop_q, drop_d;
    logic          ev, alive, pop, push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lowest-index press wins; the rest are discarded without a drop strobe.
    always_comb begin
        ev     = 1'b0;
        ev_dir = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            if (press_w[i]) begin
                ev     = 1'b1;
                ev_dir = 2'(i);
            end
        end
    end

    // Pop first, then judge the press against the post-pop reference.
    always_comb begin
        tail_idx  = (wr_q == '0) ? PW'(QUEUE_DEPTH - 1) : wr_q - 1'b1;
        alive     = (game_state == GAME_STATE_ALIVE);
        pop       = alive && tick && (cnt_q != 3'd0);
        cnt_after = cnt_q - {2'b00, pop};
        mov_d     = pop ? mem_q[rd_q] : mov_q;
        ref_dir   = (cnt_after != 3'd0) ? mem_q[tail_idx] : mov_d;
        push      = alive && ev && (cnt_after < 3'(QUEUE_DEPTH))
                    && (ev_dir != ref_dir) && (ev_dir != opposite_dir(ref_dir));
        drop_d    = alive && ev && !push;
        rd_d      = pop ? ptr_inc(rd_q) : rd_q;
        wr_d      = push ? ptr_inc(wr_q) : wr_q;
        cnt_d     = cnt_after + {2'b00, push};
        if (!alive) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = 3'd0;
        end
    end

    // Queue storage, pointers, count and applied direction.
    always_ff @(posedge clk_25_2) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= 3'd0;
            mov_q  <= 2'b00;
            drop_q <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= 2'b00;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            mov_q  <= mov_d;
            drop_q <= drop_d;
            if (push) mem_q[wr_q] <= ev_dir;
        end
    end

    assign mov_dir       = mov_q;
    assign queue_count   = cnt_q;
    assign press_dropped = drop_q;

endmodule
